// File: rtl/light_phase_timer_if.sv
// light_phase_timer_if: signal bundle between the traffic-light sequencer
// (master) and the phase timer (slave).
//
// Signalling: there is no valid/ready pair. current_state, c_sensor_state
// and ped_req are levels sampled on every clock. counter_carry_flag is a
// level that stays high until the next phase change. tick is a one-clock
// strobe. dbg_phase exposes the timer's registered copy of the phase.
interface light_phase_timer_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       current_state;
  logic             c_sensor_state;
  logic             ped_req;
  logic             counter_carry_flag;
  logic             c_demand;
  logic             ped_walk;
  logic [CNT_W-1:0] remaining;
  logic             tick;
  logic [1:0]       dbg_phase;

  modport master (
    output current_state, c_sensor_state, ped_req,
    input  counter_carry_flag, c_demand, ped_walk, remaining, tick, dbg_phase
  );

  modport slave (
    input  current_state, c_sensor_state, ped_req,
    output counter_carry_flag, c_demand, ped_walk, remaining, tick, dbg_phase
  );
endinterface

// File: rtl/light_phase_timer.sv
// light_phase_timer: per-phase countdown for the main/country traffic light
// sequencer. Loads a duration on every phase change, counts it down in
// 1-second ticks and raises a level carry flag when the phase has elapsed.
// Country green may end early (gap-out) once its minimum time has passed
// and the sensor has been quiet for CG_GAP ticks.
//
// Optional feature macro: PED_SERVICE_EN (pedestrian demand latching and
// walk indication). Undefined: ped_req ignored, ped_walk tied low and
// c_demand follows the raw sensor.
module light_phase_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 8,
  parameter int MG_MIN   = 25,
  parameter int MY_TIME  = 3,
  parameter int CG_MAX   = 15,
  parameter int CG_MIN   = 5,
  parameter int CG_GAP   = 3,
  parameter int CY_TIME  = 3
) (
  input logic                clk,
  input logic                rst,
  light_phase_timer_if.slave tmr_if
);

  typedef enum logic [1:0] {
    PH_MGCR = 2'd0,
    PH_MYCR = 2'd1,
    PH_MRCG = 2'd2,
    PH_MRCY = 2'd3
  } phase_e;

  localparam int PW          = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int L_CNT_LIMIT = (1 << CNT_W) - 1;

  localparam logic [PW-1:0]    L_PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] L_MG        = CNT_W'(MG_MIN);
  localparam logic [CNT_W-1:0] L_MY        = CNT_W'(MY_TIME);
  localparam logic [CNT_W-1:0] L_CG_MAX    = CNT_W'(CG_MAX);
  localparam logic [CNT_W-1:0] L_CY        = CNT_W'(CY_TIME);
  localparam logic [CNT_W-1:0] L_GAP       = CNT_W'(CG_GAP);
  // Remaining-time threshold at or below which the country green has run
  // at least CG_MIN ticks and may gap out.
  localparam logic [CNT_W-1:0] L_GAP_WIN   = CNT_W'(CG_MAX - CG_MIN);

  // Elaboration-time parameter sanity checks
  if (TICK_DIV < 2) begin : g_chk_div
    $error("light_phase_timer: TICK_DIV must be >= 2");
  end
  if (CG_MIN > CG_MAX) begin : g_chk_cg
    $error("light_phase_timer: CG_MIN must not exceed CG_MAX");
  end
  if (MG_MIN > L_CNT_LIMIT || MY_TIME > L_CNT_LIMIT || CG_MAX > L_CNT_LIMIT ||
      CY_TIME > L_CNT_LIMIT || CG_GAP > L_CNT_LIMIT) begin : g_chk_width
    $error("light_phase_timer: a duration parameter does not fit CNT_W");
  end

  logic [PW-1:0]    r_presc;
  logic [PW-1:0]    w_presc_nxt;
  logic             w_tick;

  phase_e           r_prev_state;
  phase_e           w_prev_nxt;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_rem_nxt;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] w_gap_nxt;
  logic             r_carry;
  logic             w_carry_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_dur;

  // Free-running prescaler; phase changes never disturb it
  always_comb begin
    w_tick      = (r_presc == L_PRESC_TOP);
    w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
  end

  // Duration of the phase the sequencer is presenting now
  always_comb begin
    w_dur = L_MG;
    case (tmr_if.current_state)
      2'd0:    w_dur = L_MG;
      2'd1:    w_dur = L_MY;
      2'd2:    w_dur = L_CG_MAX;
      default: w_dur = L_CY;
    endcase
  end

  // Next-state logic: load on phase change (wins over a coincident tick),
  // otherwise evaluate carry from current counters and count on tick
  always_comb begin
    w_load      = (tmr_if.current_state != r_prev_state);
    w_prev_nxt  = r_prev_state;
    w_rem_nxt   = r_remaining;
    w_gap_nxt   = r_gap;
    w_carry_nxt = r_carry;
    if (w_load) begin
      w_prev_nxt  = phase_e'(tmr_if.current_state);
      w_rem_nxt   = w_dur;
      w_gap_nxt   = L_GAP;
      w_carry_nxt = 1'b0;
    end else begin
      w_carry_nxt = (r_remaining == '0);
      if (r_prev_state == PH_MRCG && r_gap == '0 && r_remaining <= L_GAP_WIN) begin
        w_carry_nxt = 1'b1;
      end
      if (w_tick) begin
        if (r_remaining != '0) begin
          w_rem_nxt = r_remaining - 1'b1;
        end
        if (r_prev_state == PH_MRCG) begin
          if (tmr_if.c_sensor_state) begin
            w_gap_nxt = L_GAP;
          end else if (r_gap != '0) begin
            w_gap_nxt = r_gap - 1'b1;
          end
        end
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc      <= '0;
      r_prev_state <= PH_MGCR;
      r_remaining  <= L_MG;
      r_gap        <= L_GAP;
      r_carry      <= 1'b0;
    end else begin
      r_presc      <= w_presc_nxt;
      r_prev_state <= w_prev_nxt;
      r_remaining  <= w_rem_nxt;
      r_gap        <= w_gap_nxt;
      r_carry      <= w_carry_nxt;
    end
  end

  assign tmr_if.tick               = w_tick;
  assign tmr_if.remaining          = r_remaining;
  assign tmr_if.counter_carry_flag = r_carry;
  assign tmr_if.dbg_phase          = r_prev_state;

`ifdef PED_SERVICE_EN
  // Walk runs for the whole country green, so the walk interval is exactly
  // the time spent in that phase; the CG_MIN part of the gap-out rule
  // therefore already keeps gap-out off for the first CG_MIN walk ticks.
  logic r_ped_pending;
  logic r_ped_walk;
  logic w_pend_nxt;

  // Pedestrian latch: set by a request during main green/yellow, cleared on
  // entry to country green (clear wins a same-cycle set)
  always_comb begin
    w_pend_nxt = r_ped_pending;
    if (tmr_if.ped_req && (r_prev_state == PH_MGCR || r_prev_state == PH_MYCR)) begin
      w_pend_nxt = 1'b1;
    end
    if (w_load && tmr_if.current_state == 2'd2) begin
      w_pend_nxt = 1'b0;
    end
  end

  // Pedestrian registers; walk tracks the registered phase copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ped_pending <= 1'b0;
      r_ped_walk    <= 1'b0;
    end else begin
      r_ped_pending <= w_pend_nxt;
      r_ped_walk    <= (w_prev_nxt == PH_MRCG);
    end
  end

  assign tmr_if.c_demand = tmr_if.c_sensor_state | r_ped_pending;
  assign tmr_if.ped_walk = r_ped_walk;
`else
  logic w_unused_ped;
  assign w_unused_ped    = tmr_if.ped_req;
  assign tmr_if.c_demand = tmr_if.c_sensor_state;
  assign tmr_if.ped_walk = 1'b0;
`endif

endmodule
